// File: rtl/alu_seq_pkg.sv
// Shared opcode/state encodings and constants for the sequential ALU.
package alu_seq_pkg;

   localparam int unsigned OP_W = 4;

   typedef enum logic [OP_W-1:0] {
      OP_AND   = 4'b0000,
      OP_OR    = 4'b0001,
      OP_ADD   = 4'b0010,
      OP_XOR   = 4'b0011,
      OP_SLL   = 4'b0100,
      OP_SRL   = 4'b0101,
      OP_SUB   = 4'b0110,
      OP_SRA   = 4'b0111,
      OP_EQ    = 4'b1000,
      OP_SLT   = 4'b1001,
      OP_SLTU  = 4'b1010,
      OP_MUL   = 4'b1011,
      OP_MULHU = 4'b1100,
      OP_DIVU  = 4'b1101,
      OP_REMU  = 4'b1110,
      OP_NOP   = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   // Divide-by-zero: DIVU yields all-ones (truncate to DATA_WIDTH); REMU yields the dividend.
   localparam logic [127:0] DIVU_BY_ZERO         = '1;
   localparam bit           REMU_BY_ZERO_IS_SRCA = 1'b1;

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative radix-2 engine: shift-add multiply and restoring divide, one step per cycle.
module alu_seq_muldiv
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned SHAMT_W    = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  alu_op_e               op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic                  done_c,
   output logic [DATA_WIDTH-1:0] result_c
);

   localparam int unsigned W  = DATA_WIDTH;
   localparam int unsigned CW = SHAMT_W + 1;

   logic              busy_q, busy_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*W-1:0]    acc_q, acc_d, step_c;
   logic [W-1:0]      opnd_q, opnd_d;
   alu_op_e           op_q, op_d;
   logic              is_mul_c, start_mul_c, ge_c;
   logic [W:0]        sum_c, shifted_c;

   // acc holds {partial product, multiplier} or {remainder, quotient}
   always_comb begin
      is_mul_c    = (op_q == OP_MUL) || (op_q == OP_MULHU);
      start_mul_c = (op_i == OP_MUL) || (op_i == OP_MULHU);
      sum_c       = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
      shifted_c   = {acc_q[2*W-1:W], acc_q[W-1]};
      ge_c        = shifted_c >= {1'b0, opnd_q};
      if (is_mul_c) begin
         step_c = {sum_c, acc_q[W-1:1]};
      end else if (ge_c) begin
         step_c = {W'(shifted_c - {1'b0, opnd_q}), acc_q[W-2:0], 1'b1};
      end else begin
         step_c = {shifted_c[W-1:0], acc_q[W-2:0], 1'b0};
      end
   end

   assign done_c = busy_q && (cnt_q == CW'(W - 1));

   always_comb begin
      result_c = '0;
      case (op_q)
         OP_MUL:   result_c = step_c[W-1:0];
         OP_MULHU: result_c = step_c[2*W-1:W];
         OP_DIVU:  result_c = (opnd_q == '0) ? W'(DIVU_BY_ZERO) : step_c[W-1:0];
         OP_REMU:  result_c = step_c[2*W-1:W];
         default:  result_c = '0;
      endcase
   end

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      opnd_d = opnd_q;
      op_d   = op_q;
      if (start_i) begin
         busy_d = 1'b1;
         cnt_d  = '0;
         op_d   = op_i;
         opnd_d = start_mul_c ? a_i : b_i;
         acc_d  = {{W{1'b0}}, (start_mul_c ? b_i : a_i)};
      end else if (busy_q) begin
         acc_d = step_c;
         cnt_d = cnt_q + CW'(1);
         if (done_c) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         acc_q  <= '0;
         opnd_q <= '0;
         op_q   <= OP_AND;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         acc_q  <= acc_d;
         opnd_q <= opnd_d;
         op_q   <= op_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result; iterative MUL/MULHU/DIVU/REMU when
// ALU_SEQ_MULDIV_EN is defined, otherwise those opcodes return 0 in one cycle.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned OPCODE_LENGTH = 4,
   parameter int unsigned SHAMT_W       = $clog2(DATA_WIDTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     Zero
);

   alu_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] result_q, result_d, alu_c;
   logic                  zero_q, zero_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   alu_op_e               op_c;
   logic                  op_legal_c;
   logic [SHAMT_W-1:0]    shamt_c;

   assign op_c       = alu_op_e'(Operation[OP_W-1:0]);
   assign op_legal_c = (Operation >> OP_W) == '0;
   assign shamt_c    = SrcB[SHAMT_W-1:0];

`ifdef ALU_SEQ_MULDIV_EN
   logic                  start_c, is_muldiv_c, md_done_c;
   logic [DATA_WIDTH-1:0] md_result_c;

   assign is_muldiv_c = op_legal_c &&
                        (op_c inside {OP_MUL, OP_MULHU, OP_DIVU, OP_REMU});

   alu_seq_muldiv #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_W    (SHAMT_W)
   ) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .start_i  (start_c),
      .op_i     (op_c),
      .a_i      (SrcA),
      .b_i      (SrcB),
      .done_c   (md_done_c),
      .result_c (md_result_c)
   );
`endif

   // Single-cycle datapath; mul/div codes fall through to 0 here
   always_comb begin
      alu_c = '0;
      if (op_legal_c) begin
         case (op_c)
            OP_AND:  alu_c = SrcA & SrcB;
            OP_OR:   alu_c = SrcA | SrcB;
            OP_XOR:  alu_c = SrcA ^ SrcB;
            OP_ADD:  alu_c = SrcA + SrcB;
            OP_SUB:  alu_c = SrcA - SrcB;
            OP_EQ:   alu_c = DATA_WIDTH'(SrcA == SrcB);
            OP_SLL:  alu_c = SrcA << shamt_c;
            OP_SRL:  alu_c = SrcA >> shamt_c;
            OP_SRA:  alu_c = DATA_WIDTH'($signed(SrcA) >>> shamt_c);
            OP_SLT:  alu_c = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
            OP_SLTU: alu_c = DATA_WIDTH'(SrcA < SrcB);
            default: alu_c = '0;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
`ifdef ALU_SEQ_MULDIV_EN
      start_c  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
`ifdef ALU_SEQ_MULDIV_EN
               if (is_muldiv_c) begin
                  start_c = 1'b1;
                  state_d = BUSY;
               end else
`endif
               begin
                  result_d = alu_c;
                  zero_d   = (alu_c == '0);
                  state_d  = DONE;
               end
            end
         end
`ifdef ALU_SEQ_MULDIV_EN
         BUSY: begin
            if (md_done_c) begin
               result_d = md_result_c;
               zero_d   = (md_result_c == '0);
               state_d  = DONE;
            end
         end
`endif
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         result_q    <= '0;
         zero_q      <= 1'b1;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign ALUResult = result_q;
   assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq; expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
   localparam bit MD_EN = 1'b1;
`else
   localparam bit MD_EN = 1'b0;
`endif
   localparam int MD_LAT = MD_EN ? 33 : 1;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [3:0]  Operation;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] ALUResult;
   logic        Zero;

   int vectors;
   int miscompares;

   alu_seq #(
      .DATA_WIDTH    (32),
      .OPCODE_LENGTH (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .SrcA      (SrcA),
      .SrcB      (SrcB),
      .Operation (Operation),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ALUResult (ALUResult),
      .Zero      (Zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for one accept edge, then scramble inputs to prove they are not re-sampled
   task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      Operation = op;
      SrcA      = a;
      SrcB      = b;
      in_valid  = 1'b1;
      step();
      in_valid  = 1'b0;
      SrcA      = ~a;
      SrcB      = ~b;
      Operation = 4'hF;
   endtask

   task automatic wait_valid(output int lat);
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         step();
         lat++;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      step();
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      vectors++;
      if (ALUResult !== 32'h0) begin miscompares++; $display("FAIL reset_result: got %h expected 00000000", ALUResult); end
      vectors++;
      if (Zero !== 1'b1) begin miscompares++; $display("FAIL reset_zero: got %b expected 1", Zero); end
   endtask

   task automatic test_add_wrap();
      out_ready = 1'b1;
      drive_op(4'b0010, 32'hFFFF_FFFF, 32'h1);
      vectors++;
      if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_latency: out_valid got %b expected 1", out_valid); end
      vectors++;
      if (ALUResult !== 32'h0) begin miscompares++; $display("FAIL add_wrap_result: got %h expected 00000000", ALUResult); end
      vectors++;
      if (Zero !== 1'b1) begin miscompares++; $display("FAIL add_wrap_zero: got %b expected 1", Zero); end
      vectors++;
      if (in_ready !== 1'b0) begin miscompares++; $display("FAIL add_in_ready_done: got %b expected 0", in_ready); end
      step();
      out_ready = 1'b0;
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL add_in_ready_return: got %b expected 1", in_ready); end
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL add_out_valid_drop: got %b expected 0", out_valid); end
   endtask

   task automatic test_single_ops();
      logic [3:0]  ops [11] = '{4'b0111, 4'b1001, 4'b1010, 4'b0000, 4'b0001, 4'b0011,
                                4'b0110, 4'b1000, 4'b0100, 4'b0101, 4'b1111};
      logic [31:0] as  [11] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00F0,
                                32'h0000_00F0, 32'h0000_1234, 32'h0000_0000, 32'h0000_0005,
                                32'h0000_0001, 32'h8000_0000, 32'hDEAD_BEEF};
      logic [31:0] bs  [11] = '{32'h0000_0024, 32'h0000_0001, 32'h0000_0001, 32'h0000_003C,
                                32'h0000_000F, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0005,
                                32'h0000_0021, 32'h0000_001F, 32'h1234_5678};
      logic [31:0] exs [11] = '{32'hF800_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0030,
                                32'h0000_00FF, 32'h0000_12CB, 32'hFFFF_FFFF, 32'h0000_0001,
                                32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
      int lat;
      for (int i = 0; i < 11; i++) begin
         drive_op(ops[i], as[i], bs[i]);
         wait_valid(lat);
         vectors++;
         if (lat !== 1) begin miscompares++; $display("FAIL single_latency op=%b: got %0d expected 1", ops[i], lat); end
         vectors++;
         if (ALUResult !== exs[i]) begin miscompares++; $display("FAIL single_result op=%b: got %h expected %h", ops[i], ALUResult, exs[i]); end
         vectors++;
         if (Zero !== (exs[i] == 32'h0)) begin miscompares++; $display("FAIL single_zero op=%b: got %b expected %b", ops[i], Zero, exs[i] == 32'h0); end
         take();
      end
   endtask

   task automatic test_muldiv();
      logic [3:0]  ops [10] = '{4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1101, 4'b1110,
                                4'b1011, 4'b1100, 4'b1110, 4'b1101};
      logic [31:0] as  [10] = '{32'h0001_0000, 32'h0001_0000, 32'd100, 32'd100, 32'd5, 32'd5,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] bs  [10] = '{32'h0001_0000, 32'h0001_0000, 32'd7, 32'd7, 32'd0, 32'd0,
                                32'd3, 32'd3, 32'd0, 32'h0000_0010};
      logic [31:0] exs [10] = '{32'h0, 32'h1, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
                                32'hFFFF_FFFD, 32'h2, 32'h8000_0000, 32'h0FFF_FFFF};
      logic [31:0] ex;
      int lat;
      for (int i = 0; i < 10; i++) begin
         ex = MD_EN ? exs[i] : 32'h0;
         drive_op(ops[i], as[i], bs[i]);
         if (MD_EN) begin
            vectors++;
            if (in_ready !== 1'b0) begin miscompares++; $display("FAIL muldiv_busy_in_ready op=%b: got %b expected 0", ops[i], in_ready); end
         end
         wait_valid(lat);
         vectors++;
         if (lat !== MD_LAT) begin miscompares++; $display("FAIL muldiv_latency op=%b: got %0d expected %0d", ops[i], lat, MD_LAT); end
         vectors++;
         if (ALUResult !== ex) begin miscompares++; $display("FAIL muldiv_result op=%b a=%h b=%h: got %h expected %h", ops[i], as[i], bs[i], ALUResult, ex); end
         vectors++;
         if (Zero !== (ex == 32'h0)) begin miscompares++; $display("FAIL muldiv_zero op=%b: got %b expected %b", ops[i], Zero, ex == 32'h0); end
         take();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      drive_op(4'b0011, 32'h0000_1234, 32'h0000_00FF);
      wait_valid(lat);
      for (int c = 0; c < 10; c++) begin
         Operation = 4'b0010;
         SrcA      = 32'(c + 1);
         SrcB      = 32'h1;
         in_valid  = 1'b1;
         step();
         vectors++;
         if (ALUResult !== 32'h0000_12CB) begin miscompares++; $display("FAIL bp_result_stable cyc=%0d: got %h expected 000012cb", c, ALUResult); end
         vectors++;
         if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready cyc=%0d: got %b expected 0", c, in_ready); end
         vectors++;
         if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_out_valid cyc=%0d: got %b expected 1", c, out_valid); end
      end
      in_valid = 1'b0;
      take();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_taken_out_valid: got %b expected 0", out_valid); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_taken_in_ready: got %b expected 1", in_ready); end
      step();
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_no_ghost_op: got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      Operation = 4'b0010;
      SrcA      = 32'd2;
      SrcB      = 32'd3;
      in_valid  = 1'b1;
      step();
      vectors++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd5) begin miscompares++; $display("FAIL b2b_first: got valid=%b res=%h expected valid=1 res=00000005", out_valid, ALUResult); end
      Operation = 4'b0110;
      SrcA      = 32'd9;
      SrcB      = 32'd4;
      step();
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
      step();
      in_valid = 1'b0;
      vectors++;
      if (out_valid !== 1'b1 || ALUResult !== 32'd5) begin miscompares++; $display("FAIL b2b_second: got valid=%b res=%h expected valid=1 res=00000005", out_valid, ALUResult); end
      step();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_drain: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
   endtask

   task automatic test_reset_midop();
      int lat;
      drive_op(4'b1101, 32'd1000, 32'd3);
      repeat (9) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      vectors++;
      if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
      vectors++;
      if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
      vectors++;
      if (ALUResult !== 32'h0 || Zero !== 1'b1) begin miscompares++; $display("FAIL midrst_result: got %h zero=%b expected 00000000 zero=1", ALUResult, Zero); end
      drive_op(4'b0000, 32'h0000_00F0, 32'h0000_003C);
      wait_valid(lat);
      vectors++;
      if (lat !== 1 || ALUResult !== 32'h30) begin miscompares++; $display("FAIL midrst_and: got lat=%0d res=%h expected lat=1 res=00000030", lat, ALUResult); end
      take();
      repeat (35) step();
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_stale: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      SrcA        = '0;
      SrcB        = '0;
      Operation   = '0;
      test_reset();
      test_add_wrap();
      test_single_ops();
      test_muldiv();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle datapath ALU; adds shifts, set-less-than, and iterative unsigned multiply/divide.
- Accepts one operation at a time on a valid/ready input port and returns a registered result on a valid/ready output port.
- Sits between the execute-stage operand muxes and the writeback path; the core stalls on in_ready/out_valid.

Parameters:
- DATA_WIDTH, 32, operand and result width (≥8, power of two).
- OPCODE_LENGTH, 4, width of Operation.
- SHAMT_W, $clog2(DATA_WIDTH), shift-amount bits taken from SrcB.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and Operation are valid.
- in_ready  output  1  block can accept an operation.
- SrcA  input  DATA_WIDTH  operand A.
- SrcB  input  DATA_WIDTH  operand B.
- Operation  input  OPCODE_LENGTH  operation code.
- out_valid  output  1  ALUResult is valid.
- out_ready  input  1  consumer accepts the result.
- ALUResult  output  DATA_WIDTH  registered result.
- Zero  output  1  ALUResult == 0, registered with ALUResult.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0011 XOR; 0010 ADD; 0110 SUB; 1000 EQ (1/0).
  - 0100 SLL; 0101 SRL; 0111 SRA, with shift amount SrcB[SHAMT_W-1:0].
  - 1001 SLT (signed); 1010 SLTU.
  - 1011 MUL: low DATA_WIDTH bits of A*B. 1100 MULHU: high bits, unsigned.
  - 1101 DIVU; 1110 REMU.
  - 1111 and any undefined code: result 0, single-cycle path.
- ADD/SUB wrap modulo 2^DATA_WIDTH; no flags other than Zero.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE).
- IDLE: on in_valid, the operation is accepted.
  - Single-cycle ops: result registered, go to DONE; out_valid is high the next cycle (latency 1).
  - MUL/MULHU/DIVU/REMU: latch operands, clear a counter, go to BUSY.
- BUSY:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide.
  - After exactly DATA_WIDTH steps, load the result and go to DONE. Latency from accept to out_valid is DATA_WIDTH+1 cycles.
  - in_valid is ignored while BUSY.
- DONE: out_valid=1; ALUResult/Zero held stable until out_ready=1. On the out_ready cycle, go to IDLE.
  - No bypass: the next accept is earliest one cycle after the handshake. Peak throughput is 1 op per 2 cycles.
- Divide by zero: no special iteration. DIVU returns all-ones; REMU returns SrcA. Both still take DATA_WIDTH+1 cycles.
- MUL/MULHU use a 2*DATA_WIDTH product register; a shared iteration counter of width SHAMT_W+1 is used for both multiply and divide.
- Reset (any state, including mid-BUSY):
  - Outputs: state=IDLE, out_valid=0, ALUResult=0, Zero=1, in_ready=1 the cycle after reset deasserts.
  - Any in-flight operation is discarded.
- Inputs are sampled only at the accept edge; changes to SrcA/SrcB/Operation after accept have no effect.

Optional Feature:
- Macro: ALU_SEQ_MULDIV_EN.
- Defined: MUL/MULHU/DIVU/REMU are implemented as above.
- Undefined:
  - Those opcodes take the single-cycle path and return 0.
  - BUSY state, product/remainder registers and counter are not synthesised.
  - All ops have latency 1.

Decomposition:
- Package alu_seq_pkg holds:
  - Opcode enum alu_op_e with the encodings above.
  - FSM enum alu_state_e {IDLE, BUSY, DONE}.
  - Localparams for DIVU/REMU divide-by-zero results.
- One natural sub-module: alu_seq_muldiv, the iterative multiply/divide engine.
  - Interface: start, op, operands, done, result.
  - Instantiated only under ALU_SEQ_MULDIV_EN.
- The combinational op decode stays in alu_seq.

Test Plan (DATA_WIDTH=32):
- ADD 0xFFFFFFFF+1 with out_ready=1 -> out_valid at accept+1, ALUResult=0, Zero=1; in_ready returns 1 at accept+2.
- SRA 0x80000000 by SrcB=0x24 (shamt 4) -> 0xF8000000. SLT 0xFFFFFFFF,1 -> 1. SLTU same operands -> 0.
- MUL 0x10000,0x10000 -> 0x0; MULHU same operands -> 0x1; each out_valid exactly 33 cycles after accept.
- DIVU 100,7 -> 14; REMU 100,7 -> 2; DIVU 5,0 -> 0xFFFFFFFF; REMU 5,0 -> 5.
- Backpressure: out_ready=0 for 10 cycles in DONE -> ALUResult stable, in_ready=0, new in_valid ignored; result taken on the first out_ready=1.
- Reset asserted at cycle 10 of a DIVU -> next cycle out_valid=0, in_ready=1, ALUResult=0; a following AND 0xF0,0x3C returns 0x30.
